ones_pattern_gen: RTL
=====================

Name: ones_pattern_gen

Overview:
- Inverse of the team's registered popcount block: takes a ones-count and generates a WIDTH-bit word containing exactly that many ones.
- The word is built bit-serially under an FSM. It is emitted both as a serial stream (LSB first) and as a registered parallel word.
- Used as a stimulus/loopback source: feeding q_out into the popcount block must return the same count.

Parameters:
- WIDTH, 16, output word width in bits.
- CW, 6, count input width; must hold WIDTH (ceil(log2(WIDTH+1))+1 headroom, so out-of-range values are detectable).
- ALIGN, 0, 0 = ones packed from bit 0 upward; 1 = ones packed from bit WIDTH-1 downward.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on each rising clk edge.
- count  input  CW  requested number of ones; sampled with start.
- busy  output  1  high while a pattern is being generated.
- done  output  1  one-cycle pulse when q_out is updated.
- err  output  1  one-cycle pulse when a start is rejected.
- q_out  output  WIDTH  last completed pattern; held between operations.
- sout  output  1  serial pattern bit, LSB first.
- sout_valid  output  1  sout is meaningful this cycle.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy, done, err, sout, sout_valid=0; q_out=0; internal index and shift register cleared. Reset asserted mid-FILL aborts the operation with no done pulse.
- Target bit function:
  - ALIGN=0: bit i = (i < cnt).
  - ALIGN=1: bit i = (i >= WIDTH-cnt).
  - cnt is the latched count.
- State IDLE:
  - start=1 and count<=WIDTH: latch cnt=count, idx=0, clear shift register, busy<=1, go to FILL.
  - start=1 and count>WIDTH: err<=1 for one cycle; stay in IDLE; q_out unchanged; busy stays 0.
  - start=0: hold.
- State FILL, on each edge:
  - sout<=bit(idx), sout_valid<=1.
  - Shift register gets bit(idx) at position idx.
  - idx<=idx+1.
  - After the edge that emits idx=WIDTH-1, go to LOAD.
- State LOAD, on one edge:
  - q_out<=shift register; done<=1; busy<=0; sout_valid<=0; sout<=0; go to IDLE.
- done and err are single-cycle pulses; they deassert on the next edge.
- Timing: start accepted at edge E0. sout_valid is high in the WIDTH cycles following edges E1..E_WIDTH. done is high in the cycle following edge E_(WIDTH+1), so start-to-done latency is WIDTH+1 clocks.
- start while busy=1 is ignored, with no err and no effect on cnt.
- start during the done cycle (state is already IDLE) is accepted normally; back-to-back operations have no idle gap beyond LOAD.
- Invariants:
  - popcount(q_out) == cnt after each done.
  - The serial stream bits concatenated LSB-first equal q_out.
- Edge counts:
  - count=0 gives all-zero stream and q_out.
  - count=WIDTH gives all ones.
  - Both complete normally with done and no err.
- idx counter width is ceil(log2(WIDTH)); it never wraps within an operation and is reset to 0 on each accept.

Test Plan:
- Reset: assert rst asynchronously mid-cycle → all outputs 0 immediately; q_out=16'h0000.
- ALIGN=0, start with count=5 → sout stream 1,1,1,1,1 followed by 11 zeros over 16 valid cycles; done exactly 17 clocks after the start edge; q_out=16'h001F; busy low in the done cycle.
- count=0 → q_out=16'h0000, done pulse, err=0. Then count=16 → q_out=16'hFFFF, done, err=0.
- q_out=16'h001F held; start with count=17 → err high for exactly 1 cycle; busy never rises; q_out stays 16'h001F; no sout_valid.
- Start count=3 accepted; pulse start with count=9 at bit 4 → ignored, result 16'h0007. Start count=9 in the done cycle → accepted, next result 16'h01FF.
- Start count=12, assert rst after 7 sout bits → outputs zero, no done. ALIGN=1 instance with count=3 → q_out=16'hE000; stream is 13 zeros then 3 ones. Loopback q_out into the popcount block returns 3.

Source files
------------

// File: rtl/ones_pattern_gen.sv
// Builds a WIDTH-bit word holding exactly `count` ones, one bit per clock,
// emitting it serially (LSB first) and then as a registered parallel word.
module ones_pattern_gen #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = 6,
  parameter int unsigned ALIGN = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CW-1:0]    count,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] q_out,
  output logic             sout,
  output logic             sout_valid
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned AW = CW + 1;

  typedef enum logic [1:0] {IDLE, FILL, LOAD} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             sout_q, sout_d;
  logic             sv_q, sv_d;
  logic             tgt_bit;

  // Target bit at the current index; compared one bit wider so WIDTH fits.
  always_comb begin
    tgt_bit = 1'b0;
    if (ALIGN == 0) begin
      tgt_bit = (AW'(idx_q) < AW'(cnt_q));
    end else begin
      tgt_bit = (AW'(idx_q) >= (AW'(WIDTH) - AW'(cnt_q)));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sreg_d  = sreg_q;
    q_d     = q_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    sout_d  = 1'b0;
    sv_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (AW'(count) > AW'(WIDTH)) begin
            err_d = 1'b1;
          end else begin
            cnt_d   = count;
            idx_d   = '0;
            sreg_d  = '0;
            busy_d  = 1'b1;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        sout_d = tgt_bit;
        sv_d   = 1'b1;
        sreg_d = sreg_q | (WIDTH'(tgt_bit) << idx_q);
        idx_d  = idx_q + IW'(1);
        if (idx_q == IW'(WIDTH - 1)) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        q_d     = sreg_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sreg_q  <= '0;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sout_q  <= 1'b0;
      sv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sreg_q  <= sreg_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sout_q  <= sout_d;
      sv_q    <= sv_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign q_out      = q_q;
  assign sout       = sout_q;
  assign sout_valid = sv_q;

endmodule
